pipeline_stall_ctrl: RTL

Hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions:
- load-use hazards,
- taken branch/jump flushes,
- variable-latency data-memory accesses issued from the EX/MEM stage, handshaked via mem_ready, with a timeout watchdog.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_stall_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall sequencer: controller state codes
// and the hard-wired zero register number.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        S_RUN  = ST_RUN,
        S_WAIT = ST_WAIT,
        S_ERR  = ST_ERR
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles,
// branch flushes and variable-latency data-memory waits with a timeout.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
    localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);

    ctrl_state_e    state_r, stateNext_s;
    logic [WCW-1:0] waitCnt_r, waitCntNext_s;
    logic           memError_r, memErrorNext_s;

    logic access_s, memStall_s, luHaz_s, frozen_s;

    assign access_s   = exmem_mem_read | exmem_mem_write;
    assign memStall_s = access_s & ~mem_ready & (state_r != S_ERR);
    assign luHaz_s    = idex_mem_read & (idex_rt != REG_ZERO) &
                        ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign frozen_s   = (state_r == S_ERR) | memStall_s;

    // Controller state, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_RUN;
            waitCnt_r  <= WAIT_ZERO;
            memError_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            waitCnt_r  <= waitCntNext_s;
            memError_r <= memErrorNext_s;
        end
    end

    // Next-state logic for the memory-wait sequencer.
    always_comb begin
        stateNext_s    = state_r;
        waitCntNext_s  = waitCnt_r;
        memErrorNext_s = memError_r;
        case (state_r)
            S_RUN: begin
                if (memStall_s) begin
                    stateNext_s   = S_WAIT;
                    waitCntNext_s = WAIT_ONE;
                end else begin
                    stateNext_s   = S_RUN;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    stateNext_s   = S_RUN;
                    waitCntNext_s = WAIT_ZERO;
                end else if (waitCnt_r == WAIT_LAST) begin
                    stateNext_s    = S_ERR;
                    memErrorNext_s = 1'b1;
                end else begin
                    waitCntNext_s = waitCnt_r + WAIT_ONE;
                end
            end
            S_ERR: begin
                stateNext_s    = S_ERR;
                memErrorNext_s = 1'b1;
            end
            default: begin
                stateNext_s   = S_RUN;
                waitCntNext_s = WAIT_ZERO;
            end
        endcase
    end

    // Prioritised pipeline-register controls; everything is held off during reset.
    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        mem_req      = 1'b0;
        if (rst) begin
            mem_req = 1'b0;
        end else begin
            mem_req = access_s & (state_r != S_ERR);
            if (frozen_s) begin
                memwb_bubble = 1'b1;
            end else if (luHaz_s) begin
                idex_bubble = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end else if (branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end
        end
    end

    assign mem_error = memError_r;

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~pc_write & ~rst),
        .count (stall_cycles)
    );

endmodule
